// File: rtl/regfile_sb.sv
// regfile_sb: DEPTH x WIDTH register file, NUM_RD read ports, one byte-enabled write port, pending-write scoreboard.
// Latency: reads and rd_pend are combinational (0 cycles); writes, marks and clears take effect on the next clk edge.
// Backpressure: none; decode stalls itself on rd_pend/pend_vec, and writeback writes/clears are always accepted.
//
// Optional feature: define REGFILE_SB_BYPASS_EN for same-cycle write-to-read forwarding (data and pending clear).
//
// Ports:
//   clk, rstn          clock, synchronous active-low reset (clears storage and scoreboard)
//   rd_addr/rd_data    packed read ports; port i uses rd_addr[i*AW +: AW] and rd_data[i*WIDTH +: WIDTH]
//   rd_pend            per read port: addressed register has an outstanding mark
//   wr_en/wr_addr      write strobe and address
//   wr_be/wr_data      byte enables and write data
//   wr_clr             together with wr_en, clears the pending bit of wr_addr
//   mk_en/mk_addr      mark a register as pending (producer issued)
//   pend_vec           full registered scoreboard
module regfile_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_pend,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH/8-1:0]      wr_be,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    wr_clr,
  input  logic                    mk_en,
  input  logic [AW-1:0]           mk_addr,
  output logic [DEPTH-1:0]        pend_vec
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pend_nxt;
  logic             wr_ok;
  logic             mk_ok;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Register 0 (when hardwired) never takes data and is never marked.
  assign wr_ok = wr_en && !is_zero(wr_addr);
  assign mk_ok = mk_en && !is_zero(mk_addr);

  // Clear is applied first so that a same-cycle mark on the same register
  // wins: the new producer was issued as the old one retired.
  always_comb begin
    pend_nxt = pend;
    if (wr_en && wr_clr) pend_nxt[wr_addr] = 1'b0;
    if (mk_ok)           pend_nxt[mk_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
      pend <= '0;
    end else begin
      pend <= pend_nxt;
      if (wr_ok) begin
        for (int k = 0; k < NB; k++) begin
          if (wr_be[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  assign pend_vec = pend;

`ifdef REGFILE_SB_BYPASS_EN
  // Value the addressed register will hold after this edge.
  logic [WIDTH-1:0] wr_merged;

  always_comb begin
    wr_merged = mem[wr_addr];
    for (int k = 0; k < NB; k++) begin
      if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
    end
  end
`endif

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic             p;

    assign a = rd_addr[i*AW +: AW];

    always_comb begin
      d = mem[a];
      p = pend[a];
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_ok && (wr_addr == a)) d = wr_merged;
      // A retiring producer reads as not pending unless a new one is marked now.
      if (wr_en && wr_clr && (wr_addr == a) && !(mk_en && (mk_addr == a))) p = 1'b0;
`endif
      if (is_zero(a)) begin
        d = '0;
        p = 1'b0;
      end
    end

    assign rd_data[i*WIDTH +: WIDTH] = d;
    assign rd_pend[i]                = p;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: default instance (32x32, 2 read ports) and a
// WIDTH=16/DEPTH=8/NUM_RD=3 instance, both compared against a reference model.
module tb_regfile_sb;

`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct packed {
    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [3:0]      be;
    logic [31:0]     wd;
    logic            clr;
    logic            mk_en;
    logic [4:0]      mk_addr;
    logic [2:0][4:0] ra;
  } txn_t;

  typedef struct packed {
    logic [2:0][31:0] d;
    logic [2:0]       p;
    logic [31:0]      pv;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  txn_t cur_a, cur_b;

  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_pend;
  logic [31:0] a_pend_vec;
  logic [47:0] b_rd_data;
  logic [2:0]  b_rd_pend;
  logic [7:0]  b_pend_vec;

  regfile_sb u_dut_a (
    .clk      (clk),
    .rstn     (rstn),
    .rd_addr  ({cur_a.ra[1], cur_a.ra[0]}),
    .rd_data  (a_rd_data),
    .rd_pend  (a_rd_pend),
    .wr_en    (cur_a.wr_en),
    .wr_addr  (cur_a.wr_addr),
    .wr_be    (cur_a.be),
    .wr_data  (cur_a.wd),
    .wr_clr   (cur_a.clr),
    .mk_en    (cur_a.mk_en),
    .mk_addr  (cur_a.mk_addr),
    .pend_vec (a_pend_vec)
  );

  regfile_sb #(.WIDTH(16), .DEPTH(8), .NUM_RD(3), .ZERO_REG(1)) u_dut_b (
    .clk      (clk),
    .rstn     (rstn),
    .rd_addr  ({cur_b.ra[2][2:0], cur_b.ra[1][2:0], cur_b.ra[0][2:0]}),
    .rd_data  (b_rd_data),
    .rd_pend  (b_rd_pend),
    .wr_en    (cur_b.wr_en),
    .wr_addr  (cur_b.wr_addr[2:0]),
    .wr_be    (cur_b.be[1:0]),
    .wr_data  (cur_b.wd[15:0]),
    .wr_clr   (cur_b.clr),
    .mk_en    (cur_b.mk_en),
    .mk_addr  (cur_b.mk_addr[2:0]),
    .pend_vec (b_pend_vec)
  );

  // Reference model: register contents and pending set per instance.
  logic [31:0] mm [2][32];
  logic [31:0] mp [2];

  int total = 0;
  int bad   = 0;

  obs_t  ea_q[$];
  obs_t  eb_q[$];
  string tg_q[$];

  function automatic int wid(int n);
    return (n == 0) ? 32 : 16;
  endfunction

  function automatic int dep(int n);
    return (n == 0) ? 32 : 8;
  endfunction

  function automatic int nrd(int n);
    return (n == 0) ? 2 : 3;
  endfunction

  // What each read port should show during a cycle with inputs t.
  function automatic obs_t predict(int n, txn_t t);
    obs_t o;
    o = '0;
    for (int i = 0; i < nrd(n); i++) begin
      int          a;
      logic [31:0] v;
      logic        pb;
      a  = int'(t.ra[i]);
      v  = mm[n][a];
      pb = mp[n][a];
      if (BYP && t.wr_en && (int'(t.wr_addr) == a)) begin
        for (int k = 0; k < wid(n) / 8; k++)
          if (t.be[k]) v[8*k +: 8] = t.wd[8*k +: 8];
        if (t.clr && !(t.mk_en && (int'(t.mk_addr) == a))) pb = 1'b0;
      end
      if (a == 0) begin
        v  = '0;
        pb = 1'b0;
      end
      o.d[i] = v;
      o.p[i] = pb;
    end
    o.pv = mp[n];
    return o;
  endfunction

  // State after the clock edge that ends a cycle with inputs t.
  function automatic void commit(int n, txn_t t, logic rs);
    if (!rs) begin
      for (int r = 0; r < 32; r++) mm[n][r] = '0;
      mp[n] = '0;
      return;
    end
    if (t.wr_en && t.wr_addr != 0)
      for (int k = 0; k < wid(n) / 8; k++)
        if (t.be[k]) mm[n][t.wr_addr][8*k +: 8] = t.wd[8*k +: 8];
    if (t.wr_en && t.clr) mp[n][t.wr_addr] = 1'b0;
    if (t.mk_en && t.mk_addr != 0) mp[n][t.mk_addr] = 1'b1;
  endfunction

  function automatic txn_t rnd(int n);
    txn_t t;
    int   hi;
    t  = '0;
    hi = ((n == 0) && ($urandom_range(0, 1) == 1)) ? 7 : dep(n) - 1;
    t.wr_en   = ($urandom_range(0, 1) == 1);
    t.wr_addr = 5'($urandom_range(0, hi));
    t.be      = 4'($urandom) & ((n == 0) ? 4'hF : 4'h3);
    t.wd      = $urandom & ((n == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF);
    t.clr     = ($urandom_range(0, 1) == 1);
    t.mk_en   = ($urandom_range(0, 2) == 0);
    t.mk_addr = 5'($urandom_range(0, hi));
    for (int i = 0; i < nrd(n); i++) t.ra[i] = 5'($urandom_range(0, hi));
    if ($urandom_range(0, 3) == 0) begin
      t.mk_addr = t.wr_addr;
      t.ra[0]   = t.wr_addr;
    end
    return t;
  endfunction

  task automatic cycle(string tag, txn_t ta, txn_t tb, logic rs);
    @(posedge clk);
    #1;
    cur_a = ta;
    cur_b = tb;
    rstn  = rs;
    ea_q.push_back(predict(0, ta));
    eb_q.push_back(predict(1, tb));
    tg_q.push_back(tag);
    commit(0, ta, rs);
    commit(1, tb, rs);
  endtask

  task automatic chk(string tg, string who, obs_t act, obs_t exp);
    total++;
    if (act.d !== exp.d) begin
      bad++;
      $display("FAIL %s %s rd_data got=%h want=%h", tg, who, act.d, exp.d);
    end
    total++;
    if (act.p !== exp.p) begin
      bad++;
      $display("FAIL %s %s rd_pend got=%b want=%b", tg, who, act.p, exp.p);
    end
    total++;
    if (act.pv !== exp.pv) begin
      bad++;
      $display("FAIL %s %s pend_vec got=%h want=%h", tg, who, act.pv, exp.pv);
    end
  endtask

  // Monitor: observes both instances mid-cycle and checks against the queue.
  always @(negedge clk) begin
    obs_t  ea, eb, aa, ab;
    string tg;
    if (ea_q.size() > 0) begin
      ea = ea_q.pop_front();
      eb = eb_q.pop_front();
      tg = tg_q.pop_front();
      aa = '0;
      aa.d[0]    = a_rd_data[31:0];
      aa.d[1]    = a_rd_data[63:32];
      aa.p[1:0]  = a_rd_pend;
      aa.pv      = a_pend_vec;
      ab = '0;
      ab.d[0][15:0] = b_rd_data[15:0];
      ab.d[1][15:0] = b_rd_data[31:16];
      ab.d[2][15:0] = b_rd_data[47:32];
      ab.p          = b_rd_pend;
      ab.pv[7:0]    = b_pend_vec;
      chk(tg, "A", aa, ea);
      chk(tg, "B", ab, eb);
    end
  end

  initial begin
    txn_t t, r, idle;
    idle  = '0;
    rstn  = 1'b0;
    cur_a = '0;
    cur_b = '0;
    commit(0, idle, 1'b0);
    commit(1, idle, 1'b0);
    repeat (3) @(posedge clk);

    // Reset state
    r = '0; r.ra[0] = 5'd5; r.ra[1] = 5'd31;
    cycle("reset_state", r, idle, 1'b1);

    // Preload, then reset overrides a simultaneous write and mark
    t = '0; t.wr_en = 1'b1; t.wr_addr = 5'd5; t.be = 4'hF; t.wd = 32'hDEADBEEF;
    t.mk_en = 1'b1; t.mk_addr = 5'd5; t.ra[0] = 5'd5;
    cycle("t1_preload", t, idle, 1'b1);
    r = '0; r.ra[0] = 5'd5;
    cycle("t1_loaded", r, idle, 1'b1);
    cycle("t1_reset", t, idle, 1'b0);
    cycle("t1_after_reset", r, idle, 1'b1);

    // Byte enables
    t = '0; t.wr_en = 1'b1; t.wr_addr = 5'd3; t.be = 4'hF; t.wd = 32'h11223344;
    cycle("t2_full_wr", t, idle, 1'b1);
    t.be = 4'b0101; t.wd = 32'hAABBCCDD; t.ra[0] = 5'd3; t.ra[1] = 5'd3;
    cycle("t2_be_wr", t, idle, 1'b1);
    r = '0; r.ra[0] = 5'd3; r.ra[1] = 5'd3;
    cycle("t2_be_chk", r, idle, 1'b1);

    // Zero register ignores writes and marks
    t = '0; t.wr_en = 1'b1; t.wr_addr = 5'd0; t.be = 4'hF; t.wd = 32'hFFFFFFFF;
    t.mk_en = 1'b1; t.mk_addr = 5'd0;
    cycle("t3_zero_wr", t, idle, 1'b1);
    cycle("t3_zero_chk", idle, idle, 1'b1);

    // Scoreboard: mark wins over same-cycle clear; clear with wr_be=0
    t = '0; t.mk_en = 1'b1; t.mk_addr = 5'd7; t.ra[0] = 5'd7;
    cycle("t4_mark", t, idle, 1'b1);
    t = '0; t.wr_en = 1'b1; t.wr_addr = 5'd7; t.clr = 1'b1; t.mk_en = 1'b1; t.mk_addr = 5'd7;
    t.ra[0] = 5'd7; t.ra[1] = 5'd7;
    cycle("t4_collide", t, idle, 1'b1);
    r = '0; r.ra[0] = 5'd7;
    cycle("t4_still_pend", r, idle, 1'b1);
    t = '0; t.wr_en = 1'b1; t.wr_addr = 5'd7; t.clr = 1'b1; t.ra[0] = 5'd7;
    cycle("t4_clear", t, idle, 1'b1);
    cycle("t4_cleared", r, idle, 1'b1);

    // Read during write
    t = '0; t.wr_en = 1'b1; t.wr_addr = 5'd9; t.be = 4'hF; t.wd = 32'h5;
    cycle("t5_pre", t, idle, 1'b1);
    t.wd = 32'hA; t.ra[0] = 5'd9;
    cycle("t5_rdw", t, idle, 1'b1);
    r = '0; r.ra[0] = 5'd9;
    cycle("t5_next", r, idle, 1'b1);

    // Randomized traffic on both instances, with occasional reset
    for (int c = 0; c < 1000; c++)
      cycle("rand", rnd(0), rnd(1), ($urandom_range(0, 299) != 0));

    @(negedge clk);
    #1;
    total++;
    if (ea_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d want=0", ea_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
